// File: rtl/score_bcd_feed.sv
// score_bcd_feed: Tetris score keeper and BCD feed for the 4-digit 7-segment
// driver. Line-clear events become points. Points accumulate in binary and
// saturate at 9999. A sequential double-dabble engine converts the score to
// BCD. The display outputs (HEXS/EN) update together, once per completed
// conversion, so a partially converted value is never shown.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-low reset
//   clear_valid   single-cycle strobe, lines cleared this cycle
//   clear_lines   lines cleared (1..4 legal; other values are ignored)
//   game_restart  synchronous strobe, zero the score (beats clear_valid)
//   HEXS          BCD digits, [15:12] thousands .. [3:0] units
//   EN            digit enables with leading-zero blanking; units always lit
//   P             decimal-point mask, all points off
//   score_bin     binary score 0..9999
//   busy          conversion in progress
module score_bcd_feed (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_valid,
  input  logic [2:0]  clear_lines,
  input  logic        game_restart,
  output logic [15:0] HEXS,
  output logic [3:0]  EN,
  output logic [3:0]  P,
  output logic [13:0] score_bin,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t      state_q;
  logic        dirty_q;
  logic [29:0] sh_q;
  logic [3:0]  cnt_q;
  logic [13:0] score_q;
  logic [15:0] hexs_q;
  logic [3:0]  en_q;

  logic [3:0]  pts;
  logic        accept;
  logic [14:0] sum;
  logic [13:0] score_d;
  logic        chg;
  logic [29:0] adj;
  logic [15:0] bcd;
  logic [3:0]  en_d;

  // Points table. Illegal line counts give no points and are not accepted.
  always_comb begin
    pts    = 4'd0;
    accept = 1'b0;
    case (clear_lines)
      3'd1: begin pts = 4'd1; accept = clear_valid; end
      3'd2: begin pts = 4'd3; accept = clear_valid; end
      3'd3: begin pts = 4'd5; accept = clear_valid; end
      3'd4: begin pts = 4'd8; accept = clear_valid; end
      default: begin pts = 4'd0; accept = 1'b0; end
    endcase
  end

  // The sum is one bit wider than the score, so the clamp cannot miss a wrap.
  assign sum     = {1'b0, score_q} + {11'b0, pts};
  assign score_d = (sum > 15'd9999) ? 14'd9999 : sum[13:0];
  assign chg     = game_restart | accept;

  // Double-dabble step: each BCD nibble >= 5 gets +3, then the shift follows.
  always_comb begin
    adj = sh_q;
    for (int i = 0; i < 4; i++) begin
      if (sh_q[14+4*i +: 4] >= 4'd5)
        adj[14+4*i +: 4] = sh_q[14+4*i +: 4] + 4'd3;
    end
  end

  assign bcd  = sh_q[29:14];
  assign en_d = {bcd[15:12] != 4'd0,
                 bcd[15:8]  != 8'd0,
                 bcd[15:4]  != 12'd0,
                 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      dirty_q <= 1'b0;
      sh_q    <= '0;
      cnt_q   <= '0;
      score_q <= '0;
      hexs_q  <= '0;
      en_q    <= 4'b0001;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dirty_q) begin
            dirty_q <= 1'b0;
            sh_q    <= {16'b0, score_q};
            cnt_q   <= '0;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sh_q  <= {adj[28:0], 1'b0};
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd13) state_q <= S_DONE;
        end
        S_DONE: begin
          hexs_q  <= bcd;
          en_q    <= en_d;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (game_restart)  score_q <= '0;
      else if (accept)   score_q <= score_d;

      // A change seen in the same cycle as the load re-arms the flag, so
      // the newest score always gets converted eventually.
      if (chg) dirty_q <= 1'b1;
    end
  end

  assign HEXS      = hexs_q;
  assign EN        = en_q;
  assign P         = 4'b1111;
  assign score_bin = score_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_score_bcd_feed.sv
module tb_score_bcd_feed;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_valid;
  logic [2:0]  clear_lines;
  logic        game_restart;
  logic [15:0] HEXS;
  logic [3:0]  EN;
  logic [3:0]  P;
  logic [13:0] score_bin;
  logic        busy;

  int total = 0;
  int bad   = 0;

  score_bcd_feed dut (
    .clk(clk), .rst(rst), .clear_valid(clear_valid), .clear_lines(clear_lines),
    .game_restart(game_restart), .HEXS(HEXS), .EN(EN), .P(P),
    .score_bin(score_bin), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int points(input logic v, input logic [2:0] l);
    if (!v) return 0;
    case (l)
      3'd1: return 1;
      3'd2: return 3;
      3'd3: return 5;
      3'd4: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] to_en(input int v);
    return {v >= 1000, v >= 100, v >= 10, 1'b1};
  endfunction

  // Reference: score as clamped integer; a conversion snapshots the score,
  // takes 15 busy cycles, and the display shows the snapshot afterwards.
  int m_score, m_snap, m_disp, m_timer;
  bit m_dirty;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_score = 0; m_snap = 0; m_disp = 0; m_timer = 0; m_dirty = 0;
    end else begin
      int p;
      bit ch;
      p  = points(clear_valid, clear_lines);
      ch = game_restart || (p != 0);
      if (m_timer > 0) begin
        m_timer--;
        if (m_timer == 0) m_disp = m_snap;
      end else if (m_dirty) begin
        m_dirty = 0;
        m_snap  = m_score;
        m_timer = 15;
      end
      if (game_restart) m_score = 0;
      else if (p != 0)  m_score = (m_score + p > 9999) ? 9999 : m_score + p;
      if (ch) m_dirty = 1;
      #1;
      chk("score_bin", 32'(score_bin), 32'(m_score));
      chk("HEXS",      32'(HEXS),      32'(to_bcd(m_disp)));
      chk("EN",        32'(EN),        32'(to_en(m_disp)));
      chk("P",         32'(P),         32'hF);
      chk("busy",      32'(busy),      32'(m_timer != 0));
    end
  end

  task automatic cyc(input logic v, input logic [2:0] l, input logic r);
    @(negedge clk);
    clear_valid = v; clear_lines = l; game_restart = r;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 3'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_valid = 1'b0; clear_lines = 3'd0; game_restart = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; clear_valid = 1'b0; clear_lines = 3'd0; game_restart = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Idle after reset
    idle(20);
    chk("idle_hexs", 32'(HEXS), 32'h0000);
    chk("idle_en",   32'(EN),   32'h1);
    chk("idle_p",    32'(P),    32'hF);
    chk("idle_busy", 32'(busy), 32'h0);

    // Single 4-line event: exact latency
    cyc(1'b1, 3'd4, 1'b0);
    @(posedge clk); #1;
    chk("ev4_score", 32'(score_bin), 32'd8);
    clear_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("ev4_k15_hexs", 32'(HEXS), 32'h0000);
    chk("ev4_k15_busy", 32'(busy), 32'h1);
    @(posedge clk); #1;
    chk("ev4_k16_hexs", 32'(HEXS), 32'h0008);
    chk("ev4_k16_en",   32'(EN),   32'h1);
    chk("ev4_k16_busy", 32'(busy), 32'h0);
    idle(5);

    // Back-to-back 4,4,3 from zero
    do_reset();
    cyc(1'b1, 3'd4, 1'b0); cyc(1'b1, 3'd4, 1'b0); cyc(1'b1, 3'd3, 1'b0);
    idle(40);
    chk("b2b_hexs", 32'(HEXS), 32'h0021);
    chk("b2b_en",   32'(EN),   32'h3);

    // Illegal line counts
    cyc(1'b1, 3'd0, 1'b0); cyc(1'b1, 3'd6, 1'b0); cyc(1'b1, 3'd7, 1'b0);
    idle(3);
    chk("illegal_score", 32'(score_bin), 32'd21);
    chk("illegal_busy",  32'(busy),      32'h0);

    // Score 105, then restart colliding with an event
    do_reset();
    repeat (13) cyc(1'b1, 3'd4, 1'b0);
    cyc(1'b1, 3'd1, 1'b0);
    idle(40);
    chk("s105_hexs", 32'(HEXS), 32'h0105);
    chk("s105_en",   32'(EN),   32'h7);
    cyc(1'b1, 3'd2, 1'b1);
    @(posedge clk); #1;
    chk("restart_score", 32'(score_bin), 32'd0);
    clear_valid = 1'b0; game_restart = 1'b0;
    idle(40);
    chk("restart_hexs", 32'(HEXS), 32'h0000);
    chk("restart_en",   32'(EN),   32'h1);

    // Saturation
    do_reset();
    repeat (1248) cyc(1'b1, 3'd4, 1'b0);
    idle(2);
    chk("pre_score", 32'(score_bin), 32'd9984);
    cyc(1'b1, 3'd4, 1'b0);
    @(posedge clk); #1;
    chk("sat1_score", 32'(score_bin), 32'd9992);
    clear_valid = 1'b0;
    cyc(1'b1, 3'd4, 1'b0);
    @(posedge clk); #1;
    chk("sat2_score", 32'(score_bin), 32'd9999);
    clear_valid = 1'b0;
    idle(40);
    chk("sat_hexs", 32'(HEXS), 32'h9999);
    chk("sat_en",   32'(EN),   32'hF);

    // Async reset mid-conversion
    cyc(1'b1, 3'd1, 1'b0);
    idle(6);
    chk("mid_busy", 32'(busy), 32'h1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("arst_hexs",  32'(HEXS),      32'h0000);
    chk("arst_en",    32'(EN),        32'h1);
    chk("arst_p",     32'(P),         32'hF);
    chk("arst_busy",  32'(busy),      32'h0);
    chk("arst_score", 32'(score_bin), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic against the model
    repeat (800)
      cyc(($urandom % 3) == 0, 3'($urandom % 8), ($urandom % 60) == 0);
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_bcd_feed.md
# score_bcd_feed

Holds the Tetris score and produces the four-digit BCD word, digit enables and decimal-point mask consumed by the 7-segment display driver. Line-clear events from the game core are converted to points, accumulated in binary with saturation at 9999, and then converted to BCD by a sequential shift-add-3 (double-dabble) engine. Display outputs update atomically once per completed conversion, so the scanned display never shows a partially converted value.

## Interface
- No parameters. Widths are fixed by the 4-digit display.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `clear_valid`  in  1  single-cycle strobe: lines were cleared this cycle.
- `clear_lines`  in  3  number of lines cleared, qualified by `clear_valid`; legal values 1..4.
- `game_restart`  in  1  synchronous strobe: zero the score.
- `HEXS`  out  16  BCD digits; [15:12] thousands … [3:0] units.
- `EN`  out  4  digit enable, 1 = digit lit; bit i pairs with `HEXS[4i+3:4i]`.
- `P`  out  4  decimal-point mask, 1 = point off.
- `score_bin`  out  14  current binary score, 0..9999.
- `busy`  out  1  high while a conversion is in progress.

## Operation
- Points per event: 1 line → 1, 2 lines → 3, 3 lines → 5, 4 lines → 8.
  - `clear_lines` of 0 or 5..7 with `clear_valid` is ignored: no score change, no conversion.
- Accumulate: `score_bin <= min(score_bin + points, 9999)`.
  - The sum is computed 15 bits wide before the clamp.
  - Events are accepted every cycle, including while `busy`.
- `game_restart` sets `score_bin` to 0. If it coincides with `clear_valid`, restart wins and the event is dropped.
- Any accepted score change, or a restart, sets the `dirty` flag.
- Conversion FSM:
  - **IDLE**: if `dirty`, clear `dirty`, load shift register = {16'b0, `score_bin`}, clear the counter, go to SHIFT.
  - **SHIFT**: each cycle, first add 3 to every BCD nibble ≥ 5, then shift the 30-bit register left by 1. After 14 shifts, go to DONE.
  - **DONE**: latch the BCD nibbles into `HEXS`, latch `EN`, go to IDLE.
- A score change during SHIFT or DONE sets `dirty` again. The in-flight conversion completes and shows the older value; the FSM then reconverts from IDLE.
- Leading-zero blanking, computed from the new BCD value at DONE:
  - `EN[3] = d3≠0`
  - `EN[2] = d3≠0 | d2≠0`
  - `EN[1] = EN[2] | d1≠0`
  - `EN[0] = 1`
- `P` is constant 4'b1111.
- `busy` = state ≠ IDLE.

## Timing
- Reset (async assert, `rst` = 0) gives:
  - `score_bin` = 0, `dirty` = 0, state IDLE, `busy` = 0
  - `HEXS` = 16'h0000, `EN` = 4'b0001, `P` = 4'b1111
- Event sampled at edge k:
  - `score_bin` is updated at edge k.
  - IDLE→SHIFT load happens at edge k+1.
  - The 14 shifts occur at edges k+2..k+15.
  - DONE latches `HEXS`/`EN` at edge k+16.
- `busy` is high after edges k+1..k+15 and low after k+16.
- Worst-case event-to-display latency is 31 cycles, when an event arrives just after a load.
- `HEXS` and `EN` change only at the DONE edge, and always together.
- Reset asserted mid-conversion aborts it immediately. No partial value is ever presented.
- At saturation, further events leave `score_bin` at 9999.
  - Each such event still sets `dirty`, producing a harmless reconversion to 9999.

## Test plan
- Reset, then idle for 20 cycles → `HEXS` = 0000, `EN` = 0001, `P` = 1111, `busy` never high.
- One event with `clear_lines` = 4 at edge k → `score_bin` = 8 at k; `HEXS` = 0008 and `EN` = 0001 exactly at edge k+16; `busy` high for 15 cycles.
- Events 4, 4, 3 on consecutive cycles → single final display 0021, `EN` = 0011; no intermediate value appears on `HEXS`.
- Preload near cap (1248 events of 4 lines = 9984), then two more 4-line events → `score_bin` = 9992, then 9999 (clamped); `HEXS` = 9999, `EN` = 1111.
- `clear_lines` = 0 and `clear_lines` = 6 with `clear_valid` → no `score_bin` change, `busy` stays low.
- Score 105 displayed, then `game_restart` together with `clear_valid` (2 lines) → `score_bin` = 0, display 0000 / `EN` 0001. Separately, async reset mid-SHIFT → all outputs at reset values immediately.
